fpm_result_queue: RTL and testbench
===================================

FPM_RESULT_QUEUE -- requirements
Module: fpm_result_queue

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width of the multiplier result.
REQ-002 Parameter MANTISSA_WIDTH, default 23, mantissa field width; word width W = EXP_WIDTH+MANTISSA_WIDTH+1.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, 2 or greater.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 valid_in  input  1  upstream multiplier result valid.
REQ-008 fpm_in  input  W  multiplier result word.
REQ-009 overflow_in / underflow_in  input  1 each  multiplier exception flags for fpm_in.
REQ-010 ready_in  output  1  queue can accept a result.
REQ-011 valid_out  output  1  head entry available.
REQ-012 ready_out  input  1  consumer accepts the head entry.
REQ-013 data_out  output  W  head result word.
REQ-014 overflow_out / underflow_out  output  1 each  head entry flags.
REQ-015 class_out  output  2  head entry class: 00 finite nonzero, 01 zero, 10 infinity, 11 NaN.
REQ-016 count_out  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 clear_in  input  1  clears sticky flags.
REQ-018 ovf_sticky_out / unf_sticky_out / nan_sticky_out  output  1 each  sticky exception status.

Function
REQ-019 A push SHALL occur when valid_in && ready_in; a pop SHALL occur when valid_out && ready_out.
REQ-020 ready_in SHALL equal (count_out < DEPTH), registered-state only, with no combinational path from ready_out.
REQ-021 valid_out SHALL equal (count_out != 0); data_out, flags and class_out SHALL show the head entry (first-word fall-through).
REQ-022 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on valid_out after edge N; there is no empty-queue bypass.
REQ-023 Class SHALL be computed at push time from fpm_in: exponent all-ones with mantissa zero is infinity; exponent all-ones with mantissa nonzero is NaN; exponent and mantissa both zero is zero (either sign); anything else is 00.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; when full, only the pop occurs.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 A pop on an empty queue and a push on a full queue SHALL be impossible by handshake; state SHALL be unchanged.
REQ-027 Each sticky flag SHALL be set on any push carrying overflow_in, underflow_in or NaN class respectively, and held until clear_in.
REQ-028 If clear_in and a setting push coincide, the set SHALL win.

Reset
REQ-029 On reset: pointers and count 0, valid_out 0, ready_in 1, sticky flags 0, data_out/flags/class_out 0.
REQ-030 Reset mid-operation SHALL discard all entries; a valid_in asserted in the reset cycle SHALL be dropped.

Configuration
REQ-031 Macro FPM_STICKY_FLAGS_EN: when defined, REQ-027/028 apply; when undefined, sticky outputs SHALL be tied to 0, clear_in SHALL be ignored, and no sticky registers exist.

Structure
REQ-032 Package fpm_pkg SHALL hold EXP_WIDTH/MANTISSA_WIDTH defaults, the fp_class_t 2-bit enum and the queue entry struct (word, overflow, underflow, class).
REQ-033 Classification SHALL live in the combinational sub-module fpm_classify.

Verification
REQ-034 Reset, push 3F800000 (1.0) -> next cycle valid_out=1, data_out=3F800000, class_out=00, count_out=1.
REQ-035 Push 00000000, 80000000, 7F800000, 7FC00000, with ready_out=0 -> ready_in=0 after the 4th push, count_out=4; drain -> classes 01,01,10,11 in order.
REQ-036 Full queue, valid_in=1 and ready_out=1 held for 8 cycles -> only pops while full, then 1 push + 1 pop per cycle with count steady, pointer wrap and no lost or duplicated words.
REQ-037 Push with overflow_in=1 -> ovf_sticky_out=1; clear_in alone -> 0; clear_in with a push having underflow_in=1 -> unf_sticky_out=1.
REQ-038 Reset asserted with 3 entries and valid_in=1 -> next cycle count_out=0, valid_out=0, sticky flags 0.
REQ-039 Build without FPM_STICKY_FLAGS_EN, push 7FC00000 with overflow_in=1 -> all sticky outputs remain 0.

Source files
------------

// File: rtl/fpm_pkg.sv
// -----------------------------------------------------------------------------
// fpm_pkg
// Shared types for the floating-point multiplier result queue.
//   EXP_WIDTH_DEF / MANTISSA_WIDTH_DEF : default result field widths
//   fp_class_t   : 2-bit classification of a result word
//   fpm_entry_t  : one queue entry (word, overflow, underflow, class) laid out
//                  for the default field widths
// -----------------------------------------------------------------------------
package fpm_pkg;

    localparam int EXP_WIDTH_DEF      = 8;
    localparam int MANTISSA_WIDTH_DEF = 23;
    localparam int WORD_WIDTH_DEF     = EXP_WIDTH_DEF + MANTISSA_WIDTH_DEF + 1;

    typedef enum logic [1:0] {
        FP_CLASS_FINITE = 2'b00,
        FP_CLASS_ZERO   = 2'b01,
        FP_CLASS_INF    = 2'b10,
        FP_CLASS_NAN    = 2'b11
    } fp_class_t;

    typedef struct packed {
        logic [WORD_WIDTH_DEF-1:0] word;
        logic                      overflow;
        logic                      underflow;
        fp_class_t                 cls;
    } fpm_entry_t;

endpackage : fpm_pkg

// File: rtl/fpm_classify.sv
// -----------------------------------------------------------------------------
// fpm_classify
// Purely combinational classifier for an IEEE-style result word
// {sign, exponent, mantissa}.
//   word_in   : result word, width EXP_WIDTH+MANTISSA_WIDTH+1
//   class_out : FINITE (00), ZERO (01, either sign), INF (10), NAN (11)
// -----------------------------------------------------------------------------
module fpm_classify
    import fpm_pkg::*;
#(
    parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF,
    localparam int W             = EXP_WIDTH + MANTISSA_WIDTH + 1
) (
    input  logic [W-1:0] word_in,
    output fp_class_t    class_out
);

    logic [EXP_WIDTH-1:0]      exp_field;
    logic [MANTISSA_WIDTH-1:0] mant_field;
    logic                      unused_sign;

    assign exp_field   = word_in[W-2 -: EXP_WIDTH];
    assign mant_field  = word_in[MANTISSA_WIDTH-1:0];
    // The sign does not affect the class (+0 and -0 are both ZERO).
    assign unused_sign = word_in[W-1];

    always_comb begin
        class_out = FP_CLASS_FINITE;
        if (&exp_field) begin
            class_out = (|mant_field) ? FP_CLASS_NAN : FP_CLASS_INF;
        end else if (~|exp_field && ~|mant_field) begin
            class_out = FP_CLASS_ZERO;
        end
    end

endmodule : fpm_classify

// File: rtl/fpm_result_queue.sv
// -----------------------------------------------------------------------------
// fpm_result_queue
// First-word fall-through queue for floating-point multiplier results. Each
// entry carries the result word, its overflow/underflow flags and a class
// computed when the word is pushed.
//
// Ports
//   clock, reset                 : single clock, synchronous active-high reset
//   valid_in / ready_in          : push handshake (ready_in = not full)
//   fpm_in, overflow_in,
//   underflow_in                 : pushed result and its exception flags
//   valid_out / ready_out        : pop handshake (valid_out = not empty)
//   data_out, overflow_out,
//   underflow_out, class_out     : head entry (zero while empty)
//   count_out                    : occupancy, 0..DEPTH
//   clear_in                     : clears the sticky flags
//   ovf/unf/nan_sticky_out       : sticky exception status
//
// Build option: define FPM_STICKY_FLAGS_EN to build the sticky exception
// registers. Without it the sticky outputs are constant 0 and clear_in is
// ignored.
// -----------------------------------------------------------------------------
module fpm_result_queue
    import fpm_pkg::*;
#(
    parameter int EXP_WIDTH      = EXP_WIDTH_DEF,
    parameter int MANTISSA_WIDTH = MANTISSA_WIDTH_DEF,
    parameter int DEPTH          = 4,
    localparam int W             = EXP_WIDTH + MANTISSA_WIDTH + 1,
    localparam int AW            = $clog2(DEPTH),
    localparam int CW            = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [W-1:0]  fpm_in,
    input  logic          overflow_in,
    input  logic          underflow_in,
    output logic          ready_in,
    output logic          valid_out,
    input  logic          ready_out,
    output logic [W-1:0]  data_out,
    output logic          overflow_out,
    output logic          underflow_out,
    output logic [1:0]    class_out,
    output logic [CW-1:0] count_out,
    input  logic          clear_in,
    output logic          ovf_sticky_out,
    output logic          unf_sticky_out,
    output logic          nan_sticky_out
);

    // Same layout as fpm_entry_t, sized by this instance's field widths.
    typedef struct packed {
        logic [W-1:0] word;
        logic         overflow;
        logic         underflow;
        fp_class_t    cls;
    } entry_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    fp_class_t     push_class;
    entry_t        push_entry;
    entry_t        head_entry;
    logic          push;
    logic          pop;

    fpm_classify #(
        .EXP_WIDTH      (EXP_WIDTH),
        .MANTISSA_WIDTH (MANTISSA_WIDTH)
    ) u_classify (
        .word_in   (fpm_in),
        .class_out (push_class)
    );

    // Handshake status comes from registered occupancy only, so neither
    // ready_in nor valid_out has a combinational path from the other side.
    assign ready_in  = (count_q != FULL_COUNT);
    assign valid_out = (count_q != '0);
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;

    assign push_entry = '{word: fpm_in, overflow: overflow_in,
                          underflow: underflow_in, cls: push_class};

    always_comb begin
        // DEPTH is a power of two, so the natural roll-over of the AW-bit
        // pointers gives the modulo-DEPTH wrap.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: stale contents are never observable because the
    // head outputs are forced to zero while the queue is empty.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Asynchronous read of the head slot gives first-word fall-through.
    assign head_entry    = mem_q[rd_ptr_q];
    assign data_out      = valid_out ? head_entry.word      : '0;
    assign overflow_out  = valid_out ? head_entry.overflow  : 1'b0;
    assign underflow_out = valid_out ? head_entry.underflow : 1'b0;
    assign class_out     = valid_out ? head_entry.cls       : FP_CLASS_FINITE;
    assign count_out     = count_q;

`ifdef FPM_STICKY_FLAGS_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic unf_sticky_q, unf_sticky_d;
    logic nan_sticky_q, nan_sticky_d;

    // A setting push in the same cycle as clear_in wins over the clear.
    always_comb begin
        ovf_sticky_d = (ovf_sticky_q && !clear_in) || (push && overflow_in);
        unf_sticky_d = (unf_sticky_q && !clear_in) || (push && underflow_in);
        nan_sticky_d = (nan_sticky_q && !clear_in) ||
                       (push && (push_class == FP_CLASS_NAN));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
            nan_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
            nan_sticky_q <= nan_sticky_d;
        end
    end

    assign ovf_sticky_out = ovf_sticky_q;
    assign unf_sticky_out = unf_sticky_q;
    assign nan_sticky_out = nan_sticky_q;
`else
    logic unused_clear;
    assign unused_clear   = clear_in;
    assign ovf_sticky_out = 1'b0;
    assign unf_sticky_out = 1'b0;
    assign nan_sticky_out = 1'b0;
`endif

endmodule : fpm_result_queue

// File: tb/tb_fpm_result_queue.sv
// -----------------------------------------------------------------------------
// tb_fpm_result_queue
// Directed, self-checking bench for fpm_result_queue with default parameters
// (32-bit words, DEPTH 4). Inputs change 1 ns after the rising edge; outputs
// are sampled on the falling edge. The sticky-flag vectors follow the same
// FPM_STICKY_FLAGS_EN setting as the design build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpm_result_queue;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [W-1:0]  fpm_in;
    logic          overflow_in;
    logic          underflow_in;
    logic          ready_in;
    logic          valid_out;
    logic          ready_out;
    logic [W-1:0]  data_out;
    logic          overflow_out;
    logic          underflow_out;
    logic [1:0]    class_out;
    logic [CW-1:0] count_out;
    logic          clear_in;
    logic          ovf_sticky_out;
    logic          unf_sticky_out;
    logic          nan_sticky_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    fpm_result_queue #(
        .EXP_WIDTH      (8),
        .MANTISSA_WIDTH (23),
        .DEPTH          (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_in       (valid_in),
        .fpm_in         (fpm_in),
        .overflow_in    (overflow_in),
        .underflow_in   (underflow_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .overflow_out   (overflow_out),
        .underflow_out  (underflow_out),
        .class_out      (class_out),
        .count_out      (count_out),
        .clear_in       (clear_in),
        .ovf_sticky_out (ovf_sticky_out),
        .unf_sticky_out (unf_sticky_out),
        .nan_sticky_out (nan_sticky_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Present one push for a single clock edge, then sample on the next
    // falling edge. Called just after a rising edge.
    task automatic push_word(input logic [W-1:0] w, input logic ovf, input logic unf, input logic clr);
        valid_in     = 1'b1;
        fpm_in       = w;
        overflow_in  = ovf;
        underflow_in = unf;
        clear_in     = clr;
        @(posedge clock); #1;
        valid_in     = 1'b0;
        overflow_in  = 1'b0;
        underflow_in = 1'b0;
        clear_in     = 1'b0;
        @(negedge clock);
    endtask

    // Pop everything left, bounded by a cycle budget.
    task automatic drain();
        int budget;
        budget = 16;
        ready_out = 1'b1;
        while (valid_out && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        ready_out = 1'b0;
        @(negedge clock);
        check("drain_empty", count_out, 0);
    endtask

    logic [W-1:0] sb_words[$];
    logic [W-1:0] next_val;
    logic [W-1:0] exp_w [4];
    logic [1:0]   exp_c [4];
    logic         do_push, do_pop;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        valid_in     = 1'b1;      // must be dropped during reset
        fpm_in       = 32'h3F800000;
        overflow_in  = 1'b0;
        underflow_in = 1'b0;
        ready_out    = 1'b0;
        clear_in     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_count",     count_out,      0);
        check("rst_valid_out", valid_out,      0);
        check("rst_ready_in",  ready_in,       1);
        check("rst_data",      data_out,       0);
        check("rst_class",     class_out,      0);
        check("rst_flags",     {overflow_out, underflow_out}, 0);
        check("rst_sticky",    {ovf_sticky_out, unf_sticky_out, nan_sticky_out}, 0);

        // Single push of 1.0, visible one cycle later
        @(posedge clock); #1;
        push_word(32'h3F800000, 1'b0, 1'b0, 1'b0);
        check("one_valid", valid_out, 1);
        check("one_data",  data_out,  32'h3F800000);
        check("one_class", class_out, 2'b00);
        check("one_count", count_out, 1);
        @(posedge clock); #1;
        drain();

        // Fill with special values while the consumer stalls
        exp_w = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000};
        exp_c = '{2'b01, 2'b01, 2'b10, 2'b11};
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            push_word(exp_w[i], 1'b0, 1'b0, 1'b0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("full_ready_in", ready_in,  0);
        check("full_count",    count_out, 4);
        // Push attempt while full must be refused
        @(posedge clock); #1;
        push_word(32'h12345678, 1'b1, 1'b0, 1'b0);
        check("full_push_refused", count_out, 4);
        check("full_head_kept",    data_out,  32'h00000000);
        // Drain in order, one pop per cycle
        @(posedge clock); #1;
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("drain%0d_data", i),  data_out,  exp_w[i]);
            check($sformatf("drain%0d_class", i), class_out, exp_c[i]);
            @(posedge clock); #1;
        end
        ready_out = 1'b0;
        @(negedge clock);
        check("drained_valid", valid_out, 0);

        // Fill, then stream with valid_in and ready_out held for 8 cycles
        @(posedge clock); #1;
        sb_words.delete();
        for (int i = 0; i < 4; i++) begin
            push_word(32'h40000000 + W'(i), 1'b0, 1'b0, 1'b0);
            sb_words.push_back(32'h40000000 + W'(i));
            @(posedge clock); #1;
        end
        next_val  = 32'h40000004;
        valid_in  = 1'b1;
        fpm_in    = next_val;
        ready_out = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            check($sformatf("stream%0d_count", c), count_out, sb_words.size());
            check($sformatf("stream%0d_head", c),  data_out,  sb_words[0]);
            do_push = (sb_words.size() < DEPTH);
            do_pop  = (sb_words.size() > 0);
            @(posedge clock); #1;
            if (do_pop) void'(sb_words.pop_front());
            if (do_push) begin
                sb_words.push_back(next_val);
                next_val = next_val + 1;
                fpm_in   = next_val;
            end
        end
        valid_in = 1'b0;
        begin
            int k;
            k = 0;
            while (sb_words.size() > 0 && k < 8) begin
                @(negedge clock);
                check($sformatf("tail%0d_head", k), data_out, sb_words[0]);
                @(posedge clock); #1;
                void'(sb_words.pop_front());
                k++;
            end
        end
        ready_out = 1'b0;
        @(negedge clock);
        check("stream_empty", count_out, 0);

`ifdef FPM_STICKY_FLAGS_EN
        // Sticky set / clear / set-wins-over-clear
        @(posedge clock); #1;
        push_word(32'h3F800000, 1'b1, 1'b0, 1'b0);
        check("ovf_sticky_set", ovf_sticky_out, 1);
        check("head_overflow",  overflow_out,   1);
        clear_in = 1'b1;
        @(posedge clock); #1;
        clear_in = 1'b0;
        @(negedge clock);
        check("ovf_sticky_clr", ovf_sticky_out, 0);
        @(posedge clock); #1;
        push_word(32'h3F800000, 1'b0, 1'b1, 1'b1);
        check("unf_set_wins",   unf_sticky_out, 1);
        check("ovf_stays_clr",  ovf_sticky_out, 0);
        @(posedge clock); #1;
        push_word(32'h7FC00000, 1'b0, 1'b0, 1'b0);
        check("nan_sticky_set", nan_sticky_out, 1);
`else
        // Without the sticky option nothing latches
        @(posedge clock); #1;
        push_word(32'h7FC00000, 1'b1, 1'b0, 1'b0);
        check("nost_head_class", class_out,    2'b11);
        check("nost_head_ovf",   overflow_out, 1);
        check("nost_sticky",     {ovf_sticky_out, unf_sticky_out, nan_sticky_out}, 0);
`endif
        @(posedge clock); #1;
        drain();

        // Reset with 3 entries and valid_in high discards everything
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            push_word(32'h3F800000 + W'(i), 1'b1, 1'b0, 1'b0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("pre_rst_count", count_out, 3);
        @(posedge clock); #1;
        reset    = 1'b1;
        valid_in = 1'b1;
        fpm_in   = 32'h7FC00000;
        @(posedge clock); #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        @(negedge clock);
        check("mid_rst_count",  count_out, 0);
        check("mid_rst_valid",  valid_out, 0);
        check("mid_rst_ready",  ready_in,  1);
        check("mid_rst_sticky", {ovf_sticky_out, unf_sticky_out, nan_sticky_out}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fpm_result_queue
